int_to_fp_norm: RTL and testbench
=================================

# int_to_fp_norm

Sequential converter from a 12-bit sign-magnitude integer to the team's 13-bit floating-point format: sign, 4-bit exponent, 8-bit significand. It sits directly upstream of the floating-point greater-than comparator and supplies its `first`/`second` operands. Normalization is iterative, with one left shift per clock. The block uses a valid/ready handshake on both sides.

## Interface
- `INT_W`, 12: input width; bit INT_W-1 is the sign, the lower INT_W-1 bits are the magnitude.
- `EXP_W`, 4: exponent width; must satisfy 2^EXP_W > INT_W-1.
- `FRAC_W`, 8: significand width; must be ≤ INT_W-1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `in_data`  in  INT_W  sign-magnitude integer.
- `out_valid`  out  1  `out_data` holds a finished result.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  1+EXP_W+FRAC_W  {sign, exp, frac}; value is 0.frac × 2^exp.

## Operation
- States:
  - IDLE → NORM on `in_valid && in_ready`. On that edge load `sign <= in_data[INT_W-1]`, `mag <= in_data[INT_W-2:0]`, `exp <= INT_W-1`.
  - NORM, with `mag` MSB = 0 and `exp` ≠ 0: `mag <<= 1` and `exp -= 1`; stay in NORM.
  - NORM, with `mag` MSB = 1 or `exp` = 0: go to DONE and register `out_data`.
  - DONE → IDLE on `out_ready`; otherwise hold.
- Result fields:
  - frac = top FRAC_W bits of the normalized `mag`.
  - Low bits are truncated; no rounding.
- Zero: a magnitude of 0 exits NORM with `exp` = 0 and yields `out_data` = 0. The sign is forced to 0, so negative zero is never emitted.
- Nonzero results always have frac MSB = 1. This normalized form is what makes the downstream magnitude comparison valid.
- Handshake signals:
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
  - `in_valid` is ignored outside IDLE, with no queuing.
- `out_data` is stable for the whole of DONE and changes only on the edge that enters DONE.

## Timing
- Reset (asynchronous, immediate, from any state, including mid-NORM):
  - state = IDLE, `mag` = 0, `exp` = 0, `sign` = 0.
  - `out_data` = 0, `out_valid` = 0, `in_ready` = 1.
  - Any in-flight conversion is discarded.
- Latency, with k = number of leading zeros in the (INT_W-1)-bit magnitude, 0..10 for nonzero:
  - `out_valid` rises k+1 clock edges after the accepting edge.
  - Zero magnitude takes 12 edges (11 shifts plus exit).
- Completion:
  - The earliest new accept is on the edge after the `out_ready` edge (IDLE for one cycle).
  - Best-case throughput is one result per k+3 cycles.
- Boundary cases:
  - `out_ready` high on the same cycle DONE is entered: the result is consumed on the next edge, so `out_valid` is high for exactly 1 cycle.
  - `out_ready` held low: the block stalls in DONE indefinitely.

## Structure
- Shared package holds:
  - format constants `FP_EXP_W`=4, `FP_FRAC_W`=8, `FP_W`=13, `INT_W`=12;
  - the state enum `{IDLE, NORM, DONE}`;
  - field-position constants for sign, exp and frac, shared with the comparator.
- Single module; no sub-module. The datapath (shift register, down-counter, output register) is small enough to stay inline.

## Test plan
- `in_data`=12'h7FF (+2047) → after 1 edge `out_data`=13'h0BFF (exp 11, frac 8'hFF; low 3 bits truncated), `out_valid` high 1 cycle with `out_ready` tied high.
- `in_data`=12'h001 (+1) → after 11 edges `out_data`=13'h0180; `in_data`=12'hC00 (−1024) → after 1 edge `out_data`=13'h1B80.
- `in_data`=12'h800 (−0) and 12'h000 → after 12 edges `out_data`=13'h0000; sign must be 0 in both.
- Convert +5 and +4 → 13'h03A0 and 13'h0380; drive the comparator with first=+5 result, second=+4 result → gt=1; swapped → gt=0.
- Hold `out_ready`=0 for 20 cycles after a result and pulse `in_valid` with 12'h123 → `out_data` unchanged, `in_ready`=0, new input not taken; release → IDLE one cycle later, then 12'h123 is accepted.
- Assert `rst_n`=0 for half a cycle during NORM of 12'h001 → outputs reset immediately (`out_valid`=0, `out_data`=0, `in_ready`=1); no stale result after release.

Source files
------------

// File: rtl/int_to_fp_norm_pkg.sv
// Shared constants and types for the 13-bit {sign, exp, frac} float format
// used by the integer-to-float normalizer and the float comparator.
package int_to_fp_norm_pkg;

    localparam int unsigned INT_W     = 12;
    localparam int unsigned FP_EXP_W  = 4;
    localparam int unsigned FP_FRAC_W = 8;
    localparam int unsigned FP_W      = 1 + FP_EXP_W + FP_FRAC_W;

    // Field positions inside a packed FP_W-bit word.
    localparam int unsigned FP_SIGN_POS = FP_W - 1;
    localparam int unsigned FP_EXP_MSB  = FP_W - 2;
    localparam int unsigned FP_EXP_LSB  = FP_FRAC_W;
    localparam int unsigned FP_FRAC_MSB = FP_FRAC_W - 1;
    localparam int unsigned FP_FRAC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/int_to_fp_norm.sv
// Iterative sign-magnitude integer to {sign, exp, frac} float converter.
// One left shift per clock until the magnitude MSB is set or exp reaches 0.
module int_to_fp_norm #(
    parameter int unsigned INT_W  = int_to_fp_norm_pkg::INT_W,
    parameter int unsigned EXP_W  = int_to_fp_norm_pkg::FP_EXP_W,
    parameter int unsigned FRAC_W = int_to_fp_norm_pkg::FP_FRAC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INT_W-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_data
);
    import int_to_fp_norm_pkg::*;

    localparam int unsigned MAG_W = INT_W - 1;
    localparam int unsigned OUT_W = 1 + EXP_W + FRAC_W;

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               mag_zero;

    assign mag_zero  = (mag_q == '0);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[INT_W-1];
                    mag_d   = in_data[INT_W-2:0];
                    exp_d   = EXP_W'(INT_W - 1);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (!mag_q[MAG_W-1] && (exp_q != '0)) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 1'b1;
                end else begin
                    // Zero magnitude exits with exp 0; force sign so -0 never appears.
                    out_d   = {mag_zero ? 1'b0 : sign_q, exp_q, mag_q[MAG_W-1 -: FRAC_W]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_int_to_fp_norm.sv
// Directed bench for int_to_fp_norm: results, latency, handshake, stall and reset.
module tb_int_to_fp_norm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    logic [12:0] r5, r4, r_tmp;

    always #5 clk = ~clk;

    int_to_fp_norm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference comparator: magnitude order of normalized values, sign-aware.
    function automatic logic fp_gt(input logic [12:0] a, input logic [12:0] b);
        if (a[12] != b[12]) return (a[12] == 1'b0) && (a[11:0] != 0 || b[11:0] != 0);
        if (a[12] == 1'b0)  return a[11:0] > b[11:0];
        return a[11:0] < b[11:0];
    endfunction

    // Starts at posedge+1 in IDLE; out_ready held high, so out_valid must pulse one cycle.
    task automatic convert(input string tag, input logic [11:0] d, input logic [12:0] expv,
                           input int lat, output logic [12:0] res);
        int edges;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(lat));
        chk({tag, "_data"}, 32'(out_data), 32'(expv));
        res = out_data;
        @(posedge clk); #1;
        chk({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
        chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int edges;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        #13 rst_n = 1'b1;
        @(posedge clk); #1;

        convert("pos2047", 12'h7FF, 13'h0BFF, 1, r_tmp);
        convert("pos1", 12'h001, 13'h0180, 11, r_tmp);
        convert("neg1024", 12'hC00, 13'h1B80, 1, r_tmp);
        convert("neg0", 12'h800, 13'h0000, 12, r_tmp);
        convert("pos0", 12'h000, 13'h0000, 12, r_tmp);
        convert("pos5", 12'h005, 13'h03A0, 9, r5);
        convert("pos4", 12'h004, 13'h0380, 9, r4);
        chk("gt_5_4", 32'(fp_gt(r5, r4)), 32'd1);
        chk("gt_4_5", 32'(fp_gt(r4, r5)), 32'd0);

        // Stall in DONE with out_ready low while a new input is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 12'h005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("stall_latency", 32'(edges), 32'd9);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i >= 5 && i < 8);
            in_data  = 12'h123;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_data", 32'(out_data), 32'h03A0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", 32'(in_ready), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd0);
        convert("pos123", 12'h123, 13'h0991, 3, r_tmp);

        // Asynchronous reset in the middle of normalizing +1.
        in_valid = 1'b1;
        in_data  = 12'h001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midnorm_busy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        #4 rst_n = 1'b1;
        edges = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) edges++;
        end
        chk("no_stale_result", 32'(edges), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd0);
        convert("post_rst_pos1", 12'h001, 13'h0180, 11, r_tmp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
